// File: rtl/sys_ctrl_pkg.sv
// Shared types, default opcodes and the clog2 helper for the system controller.
// Optional frame timeout is enabled with SYS_CTRL_TIMEOUT_EN.
package sys_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_WAIT_RD  = 4'd4,
        ST_OPA      = 4'd5,
        ST_OPB      = 4'd6,
        ST_ALU_FUN  = 4'd7,
        ST_WAIT_ALU = 4'd8
    } ctrl_state_t;

    localparam logic [7:0] DEF_CMD_WR      = 8'hAA;
    localparam logic [7:0] DEF_CMD_RD      = 8'hBB;
    localparam logic [7:0] DEF_CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] DEF_CMD_ALU_NOP = 8'hDD;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sys_ctrl_if.sv
// Bus bundle between the system controller and its RX/TX, register-file and ALU neighbours.
// The master modport is the controller's view.
interface sys_ctrl_if #(
    parameter int WIDTH     = 8,
    parameter int ADDR      = 4,
    parameter int FUN_WIDTH = 4,
    parameter int OUT_WIDTH = 16
);
    logic                 RX_D_VLD;
    logic [WIDTH-1:0]     RX_P_DATA;
    logic                 Busy;
    logic [OUT_WIDTH-1:0] ALU_OUT;
    logic                 ALU_OUT_VALID;
    logic [WIDTH-1:0]     Rd_DATA;
    logic                 Rd_DATA_Valid;
    logic [WIDTH-1:0]     TX_P_DATA;
    logic                 TX_D_VLD;
    logic [FUN_WIDTH-1:0] FUN;
    logic                 EN;
    logic                 WrEn;
    logic                 RdEn;
    logic [ADDR-1:0]      Addr;
    logic [WIDTH-1:0]     Wr_D;
    logic                 Gate_EN;
    logic                 CMD_ERR;
    logic                 RESP_OVF;

    modport master (
        input  RX_D_VLD, RX_P_DATA, Busy, ALU_OUT, ALU_OUT_VALID, Rd_DATA, Rd_DATA_Valid,
        output TX_P_DATA, TX_D_VLD, FUN, EN, WrEn, RdEn, Addr, Wr_D, Gate_EN, CMD_ERR, RESP_OVF
    );

    modport slave (
        output RX_D_VLD, RX_P_DATA, Busy, ALU_OUT, ALU_OUT_VALID, Rd_DATA, Rd_DATA_Valid,
        input  TX_P_DATA, TX_D_VLD, FUN, EN, WrEn, RdEn, Addr, Wr_D, Gate_EN, CMD_ERR, RESP_OVF
    );

endinterface

// File: rtl/sys_ctrl_resp_fifo.sv
// Response byte FIFO: accepts up to MAX_PUSH bytes per push (LS byte first), pops one byte.
// The caller checks free space before pushing; a push and a pop in one cycle are both applied.
module sys_ctrl_resp_fifo
    import sys_ctrl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int MAX_PUSH = 2,
    localparam int PW      = clog2(DEPTH),
    localparam int CW      = PW + 1,
    localparam int LW      = clog2(MAX_PUSH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [LW-1:0]             push_len,
    input  logic [MAX_PUSH*WIDTH-1:0] push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head,
    output logic [CW-1:0]             count,
    output logic [CW-1:0]             free
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < MAX_PUSH; i++) begin
                if (LW'(i) < push_len)
                    mem[wr_ptr_reg + PW'(i)] <= push_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(push_len);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_reg + (push ? CW'(push_len) : '0) - (pop ? CW'(1) : '0);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign free  = CW'(DEPTH) - count_reg;

endmodule

// File: rtl/sys_ctrl_mc.sv
// System controller: decodes RX command frames into register-file/ALU actions and streams
// buffered responses to UART TX. Define SYS_CTRL_TIMEOUT_EN to abort stalled frames.
module sys_ctrl_mc
    import sys_ctrl_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               ADDR        = 4,
    parameter int               FUN_WIDTH   = 4,
    parameter int               OUT_WIDTH   = 16,
    parameter int               RESP_DEPTH  = 4,
    parameter logic [WIDTH-1:0] CMD_WR      = WIDTH'(DEF_CMD_WR),
    parameter logic [WIDTH-1:0] CMD_RD      = WIDTH'(DEF_CMD_RD),
    parameter logic [WIDTH-1:0] CMD_ALU_OP  = WIDTH'(DEF_CMD_ALU_OP),
    parameter logic [WIDTH-1:0] CMD_ALU_NOP = WIDTH'(DEF_CMD_ALU_NOP)
`ifdef SYS_CTRL_TIMEOUT_EN
    , parameter int             TIMEOUT_CYC = 1024
`endif
) (
    input  logic       clk,
    input  logic       rst,
    sys_ctrl_if.master bus
);
    localparam int OUT_BYTES = OUT_WIDTH / WIDTH;
    localparam int CW        = clog2(RESP_DEPTH) + 1;
    localparam int LW        = clog2(OUT_BYTES) + 1;

    localparam logic [3:0] S_IDLE     = ST_IDLE;
    localparam logic [3:0] S_WR_ADDR  = ST_WR_ADDR;
    localparam logic [3:0] S_WR_DATA  = ST_WR_DATA;
    localparam logic [3:0] S_RD_ADDR  = ST_RD_ADDR;
    localparam logic [3:0] S_WAIT_RD  = ST_WAIT_RD;
    localparam logic [3:0] S_OPA      = ST_OPA;
    localparam logic [3:0] S_OPB      = ST_OPB;
    localparam logic [3:0] S_ALU_FUN  = ST_ALU_FUN;
    localparam logic [3:0] S_WAIT_ALU = ST_WAIT_ALU;

    logic [3:0]           state_reg;
    logic [ADDR-1:0]      frame_addr_reg;
    logic [ADDR-1:0]      addr_reg;
    logic [WIDTH-1:0]     wr_d_reg;
    logic [FUN_WIDTH-1:0] fun_reg;
    logic                 wr_en_reg, rd_en_reg, en_reg, gate_en_reg;
    logic                 cmd_err_reg, resp_ovf_reg;
    logic                 tx_vld_reg;
    logic [WIDTH-1:0]     tx_data_reg;

    logic                 rd_resp, alu_resp, push_req, push_ok, pop;
    logic [LW-1:0]        push_len;
    logic [OUT_WIDTH-1:0] push_data;
    logic [WIDTH-1:0]     fifo_head;
    logic [CW-1:0]        fifo_count, fifo_free, room;
    logic                 timeout;

    // A pop in the same cycle frees a slot that the push may already use.
    always_comb begin
        rd_resp   = (state_reg == S_WAIT_RD) && bus.Rd_DATA_Valid;
        alu_resp  = (state_reg == S_WAIT_ALU) && bus.ALU_OUT_VALID;
        push_req  = rd_resp || alu_resp;
        push_len  = alu_resp ? LW'(OUT_BYTES) : LW'(1);
        push_data = alu_resp ? bus.ALU_OUT : OUT_WIDTH'(bus.Rd_DATA);
        pop       = tx_vld_reg && bus.Busy;
        room      = fifo_free + CW'(pop);
        push_ok   = push_req && (CW'(push_len) <= room);
    end

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] tmo_cnt_reg;

    assign timeout = (state_reg != S_IDLE) && !bus.RX_D_VLD && !push_req &&
                     (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tmo_cnt_reg <= '0;
        else if (state_reg == S_IDLE || bus.RX_D_VLD || timeout)
            tmo_cnt_reg <= '0;
        else
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            frame_addr_reg <= '0;
            addr_reg       <= '0;
            wr_d_reg       <= '0;
            fun_reg        <= '0;
            wr_en_reg      <= 1'b0;
            rd_en_reg      <= 1'b0;
            en_reg         <= 1'b0;
            gate_en_reg    <= 1'b0;
            cmd_err_reg    <= 1'b0;
            resp_ovf_reg   <= 1'b0;
        end else begin
            wr_en_reg <= 1'b0;
            rd_en_reg <= 1'b0;
            if (push_req && !push_ok)
                resp_ovf_reg <= 1'b1;

            case (state_reg)
                S_IDLE: if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == CMD_WR)
                        state_reg <= S_WR_ADDR;
                    else if (bus.RX_P_DATA == CMD_RD)
                        state_reg <= S_RD_ADDR;
                    else if (bus.RX_P_DATA == CMD_ALU_OP) begin
                        state_reg   <= S_OPA;
                        gate_en_reg <= 1'b1;
                    end else if (bus.RX_P_DATA == CMD_ALU_NOP) begin
                        state_reg   <= S_ALU_FUN;
                        gate_en_reg <= 1'b1;
                    end else
                        cmd_err_reg <= 1'b1;
                end
                S_WR_ADDR: if (bus.RX_D_VLD) begin
                    frame_addr_reg <= bus.RX_P_DATA[ADDR-1:0];
                    state_reg      <= S_WR_DATA;
                end
                S_WR_DATA: if (bus.RX_D_VLD) begin
                    wr_en_reg <= 1'b1;
                    addr_reg  <= frame_addr_reg;
                    wr_d_reg  <= bus.RX_P_DATA;
                    state_reg <= S_IDLE;
                end
                S_RD_ADDR: if (bus.RX_D_VLD) begin
                    rd_en_reg <= 1'b1;
                    addr_reg  <= bus.RX_P_DATA[ADDR-1:0];
                    state_reg <= S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    if (bus.RX_D_VLD)
                        cmd_err_reg <= 1'b1;
                    if (rd_resp)
                        state_reg <= S_IDLE;
                end
                S_OPA: if (bus.RX_D_VLD) begin
                    wr_en_reg <= 1'b1;
                    addr_reg  <= ADDR'(0);
                    wr_d_reg  <= bus.RX_P_DATA;
                    state_reg <= S_OPB;
                end
                S_OPB: if (bus.RX_D_VLD) begin
                    wr_en_reg <= 1'b1;
                    addr_reg  <= ADDR'(1);
                    wr_d_reg  <= bus.RX_P_DATA;
                    state_reg <= S_ALU_FUN;
                end
                S_ALU_FUN: if (bus.RX_D_VLD) begin
                    fun_reg   <= bus.RX_P_DATA[FUN_WIDTH-1:0];
                    en_reg    <= 1'b1;
                    state_reg <= S_WAIT_ALU;
                end
                S_WAIT_ALU: begin
                    if (bus.RX_D_VLD)
                        cmd_err_reg <= 1'b1;
                    if (alu_resp) begin
                        en_reg      <= 1'b0;
                        gate_en_reg <= 1'b0;
                        state_reg   <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            if (timeout) begin
                state_reg   <= S_IDLE;
                cmd_err_reg <= 1'b1;
                en_reg      <= 1'b0;
                gate_en_reg <= 1'b0;
            end
        end
    end

    // Offer a byte only while Busy is low; hold it until Busy is seen high, then pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_vld_reg  <= 1'b0;
            tx_data_reg <= '0;
        end else if (tx_vld_reg) begin
            if (bus.Busy)
                tx_vld_reg <= 1'b0;
        end else if (fifo_count != '0 && !bus.Busy) begin
            tx_vld_reg  <= 1'b1;
            tx_data_reg <= fifo_head;
        end
    end

    sys_ctrl_resp_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (RESP_DEPTH),
        .MAX_PUSH (OUT_BYTES)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_len  (push_len),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .free      (fifo_free)
    );

    assign bus.TX_P_DATA = tx_data_reg;
    assign bus.TX_D_VLD  = tx_vld_reg;
    assign bus.FUN       = fun_reg;
    assign bus.EN        = en_reg;
    assign bus.WrEn      = wr_en_reg;
    assign bus.RdEn      = rd_en_reg;
    assign bus.Addr      = addr_reg;
    assign bus.Wr_D      = wr_d_reg;
    assign bus.Gate_EN   = gate_en_reg;
    assign bus.CMD_ERR   = cmd_err_reg;
    assign bus.RESP_OVF  = resp_ovf_reg;

endmodule

// File: tb/tb_sys_ctrl_mc.sv
// Scoreboard bench for sys_ctrl_mc: directed frames push expected TX bytes and register-file
// events into queues; monitor processes pop and compare whenever the DUT presents them.
module tb_sys_ctrl_mc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sys_ctrl_if #(.WIDTH(8), .ADDR(4), .FUN_WIDTH(4), .OUT_WIDTH(16)) bus ();

    sys_ctrl_mc #(
        .WIDTH(8), .ADDR(4), .FUN_WIDTH(4), .OUT_WIDTH(16), .RESP_DEPTH(4)
`ifdef SYS_CTRL_TIMEOUT_EN
        , .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  tx_q [$];
    logic [11:0] wr_q [$];
    logic [3:0]  rd_q [$];

    logic force_busy = 1'b0;
    int   busy_lag   = 2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Register-file monitor: every WrEn/RdEn cycle must match the next expected event.
    initial begin
        logic [11:0] we;
        logic [3:0]  re;
        forever begin
            @(negedge clk);
            if (bus.WrEn === 1'b1) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write", bus.Addr, bus.Wr_D);
                end else begin
                    we = wr_q.pop_front();
                    $display("wr   addr 0x%0h data 0x%0h", bus.Addr, bus.Wr_D);
                    check("wr_addr", 32'(bus.Addr), 32'(we[11:8]));
                    check("wr_data", 32'(bus.Wr_D), 32'(we[7:0]));
                end
            end
            if (bus.RdEn === 1'b1) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rd_unexpected: got addr 0x%0h, expected no read", bus.Addr);
                end else begin
                    re = rd_q.pop_front();
                    $display("rd   addr 0x%0h", bus.Addr);
                    check("rd_addr", 32'(bus.Addr), 32'(re));
                end
            end
        end
    end

    // UART TX model: accepts a byte busy_lag cycles after TX_D_VLD, then stays Busy 3 cycles.
    initial begin
        int         busy_cnt;
        int         lag_cnt;
        logic [7:0] seen;
        logic [7:0] want;
        busy_cnt = 0;
        lag_cnt  = 0;
        seen     = '0;
        bus.Busy = 1'b0;
        forever begin
            @(negedge clk);
            if (force_busy) begin
                bus.Busy = 1'b1;
            end else if (busy_cnt != 0) begin
                if (busy_cnt == 3)
                    check("tx_vld_drop", 32'(bus.TX_D_VLD), 32'd0);
                busy_cnt--;
                if (busy_cnt == 0)
                    bus.Busy = 1'b0;
            end else if (bus.TX_D_VLD === 1'b1) begin
                if (lag_cnt == 0) begin
                    seen = bus.TX_P_DATA;
                    if (tx_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL tx_unexpected: got 0x%0h, expected no TX byte", bus.TX_P_DATA);
                    end else begin
                        want = tx_q.pop_front();
                        $display("tx   byte 0x%0h", bus.TX_P_DATA);
                        check("tx_byte", 32'(bus.TX_P_DATA), 32'(want));
                    end
                end else begin
                    check("tx_hold", 32'(bus.TX_P_DATA), 32'(seen));
                end
                if (lag_cnt >= busy_lag) begin
                    bus.Busy = 1'b1;
                    busy_cnt = 3;
                    lag_cnt  = 0;
                end else begin
                    lag_cnt++;
                end
            end else begin
                bus.Busy = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(negedge clk);
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic alu_resp(input logic [15:0] v);
        @(negedge clk);
        bus.ALU_OUT       = v;
        bus.ALU_OUT_VALID = 1'b1;
        @(negedge clk);
        bus.ALU_OUT_VALID = 1'b0;
    endtask

    task automatic rd_resp(input logic [7:0] v);
        @(negedge clk);
        bus.Rd_DATA       = v;
        bus.Rd_DATA_Valid = 1'b1;
        @(negedge clk);
        bus.Rd_DATA_Valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((tx_q.size() + wr_q.size() + rd_q.size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if ((tx_q.size() + wr_q.size() + rd_q.size()) != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d tx / %0d wr / %0d rd still pending, expected 0",
                     name, tx_q.size(), wr_q.size(), rd_q.size());
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b0;
        #13;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.RX_D_VLD      = 1'b0;
        bus.RX_P_DATA     = '0;
        bus.ALU_OUT       = '0;
        bus.ALU_OUT_VALID = 1'b0;
        bus.Rd_DATA       = '0;
        bus.Rd_DATA_Valid = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tx", {bus.TX_D_VLD, bus.TX_P_DATA}, 32'd0);
        check("rst_rf", {bus.WrEn, bus.RdEn, bus.Addr, bus.Wr_D}, 32'd0);
        check("rst_alu", {bus.EN, bus.Gate_EN, bus.FUN}, 32'd0);
        check("rst_flags", {bus.CMD_ERR, bus.RESP_OVF}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Register write: one WrEn pulse, no TX traffic.
        wr_q.push_back({4'h5, 8'h3C});
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        drain("wr");

        // Register read: response byte travels through the FIFO to TX.
        rd_q.push_back(4'h5);
        tx_q.push_back(8'h3C);
        send_byte(8'hBB); send_byte(8'h05);
        @(negedge clk);
        rd_resp(8'h3C);
        drain("rd");

        // ALU with operands: two operand writes, EN/FUN held, 2-byte response LS first.
        wr_q.push_back({4'h0, 8'h12});
        wr_q.push_back({4'h1, 8'h34});
        send_byte(8'hCC);
        check("gate_on_opa", 32'(bus.Gate_EN), 32'd1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h01);
        check("alu_en", 32'(bus.EN), 32'd1);
        check("alu_fun", 32'(bus.FUN), 32'd1);
        repeat (3) @(negedge clk);
        check("alu_en_held", {bus.EN, bus.Gate_EN}, 32'd3);
        tx_q.push_back(8'h46);
        tx_q.push_back(8'h02);
        alu_resp(16'h0246);
        check("alu_en_drop", {bus.EN, bus.Gate_EN}, 32'd0);
        drain("alu");

        // Busy stuck high: two NOP results fill 4 bytes, the third is dropped.
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        tx_q.push_back(8'hB2); tx_q.push_back(8'hA1);
        send_byte(8'hDD); send_byte(8'h03); alu_resp(16'hA1B2);
        tx_q.push_back(8'hD4); tx_q.push_back(8'hC3);
        send_byte(8'hDD); send_byte(8'h05); alu_resp(16'hC3D4);
        check("ovf_not_yet", {bus.RESP_OVF, bus.TX_D_VLD}, 32'd0);
        send_byte(8'hDD); send_byte(8'h07);
        check("nop_fun", 32'(bus.FUN), 32'd7);
        alu_resp(16'hE5F6);
        check("ovf_set", 32'(bus.RESP_OVF), 32'd1);
        repeat (2) @(negedge clk);
        force_busy = 1'b0;
        drain("ovf");

        // Byte during WAIT_ALU is dropped and flagged; the command still completes.
        check("err_clear", 32'(bus.CMD_ERR), 32'd0);
        send_byte(8'hDD); send_byte(8'h02);
        send_byte(8'h55);
        check("err_wait_alu", 32'(bus.CMD_ERR), 32'd1);
        tx_q.push_back(8'h02); tx_q.push_back(8'h01);
        alu_resp(16'h0102);
        drain("err_alu");

        // Reset mid-frame discards the partial frame and clears flags.
        send_byte(8'hAA); send_byte(8'h05);
        pulse_reset();
        check("rst_flags_clr", {bus.CMD_ERR, bus.RESP_OVF, bus.Gate_EN}, 32'd0);

        // Unknown opcode, then a normal write frame.
        send_byte(8'h77);
        check("err_opcode", 32'(bus.CMD_ERR), 32'd1);
        wr_q.push_back({4'h9, 8'h5A});
        send_byte(8'hAA); send_byte(8'h09); send_byte(8'h5A);
        drain("after_err");

`ifdef SYS_CTRL_TIMEOUT_EN
        // Partial frame abandoned after 16 idle cycles: no write, CMD_ERR set.
        pulse_reset();
        send_byte(8'hAA); send_byte(8'h05);
        repeat (20) @(negedge clk);
        check("tmo_err", 32'(bus.CMD_ERR), 32'd1);
        send_byte(8'h3C);
        wr_q.push_back({4'h5, 8'h3C});
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        drain("tmo");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
